// File: rtl/pmod_pwm_dac_pkg.sv
// Shared constants and helpers for the pmod_pwm_dac block.
// Optional feature macro used elsewhere in this block: PMOD_PWM_DAC_SD_EN.
package pmod_pwm_dac_pkg;

  localparam int DEFAULT_WIDTH    = 12;
  localparam int DEFAULT_CHANNELS = 2;

  // Widest sample the conversion helper handles.
  localparam int MAX_WIDTH = 32;

  // Two's-complement sample to offset-binary duty: flip the sign bit of a
  // w-bit value held in the low bits of s. Callers truncate back to w bits.
  function automatic logic [MAX_WIDTH-1:0] offset_binary(
    input logic [MAX_WIDTH-1:0] s,
    input int unsigned          w
  );
    return s ^ (MAX_WIDTH'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/pmod_pwm_dac_if.sv
// Sample handshake bundle for pmod_pwm_dac.
// Handshake: a word moves when sample_valid && sample_ready are both high on
// a rising clk edge; the master holds sample stable while valid is high and
// the slave raises ready only when it can take the word that same edge.
interface pmod_pwm_dac_if
  import pmod_pwm_dac_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
);

  logic [CHANNELS*WIDTH-1:0] sample;
  logic                      sample_valid;
  logic                      sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/pmod_pwm_dac_chan.sv
// One output channel: active duty register, PWM comparator and, when
// PMOD_PWM_DAC_SD_EN is defined, a first-order sigma-delta accumulator.
module pmod_pwm_dac_chan
  import pmod_pwm_dac_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,       // copy sample_in into active this edge
  input  logic [WIDTH-1:0] sample_in,  // two's-complement pending sample
  input  logic [WIDTH-1:0] counter,
`ifdef PMOD_PWM_DAC_SD_EN
  input  logic             sd_mode,
`endif
  output logic             pwm
);

  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  // Active duty only changes at a period boundary when the top says so.
  always_comb begin
    active_d = active_q;
    if (load) begin
      active_d = WIDTH'(offset_binary(MAX_WIDTH'(sample_in), WIDTH));
    end
  end

`ifdef PMOD_PWM_DAC_SD_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   acc_sum;

  // Accumulate the duty each cycle; the carry out is the modulated bit.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, active_q};
    acc_d   = enable ? acc_sum[WIDTH-1:0] : '0;
  end

  // Output bit: carry in sigma-delta mode, counter compare otherwise.
  always_comb begin
    pwm_d = 1'b0;
    if (enable) begin
      pwm_d = sd_mode ? acc_sum[WIDTH] : (counter < active_q);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  // Output bit: high while the counter is below the duty.
  always_comb begin
    pwm_d = 1'b0;
    if (enable) begin
      pwm_d = (counter < active_q);
    end
  end
`endif

  // Duty and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pmod_pwm_dac.sv
// Multi-channel PWM DAC with a one-word pending buffer. The shared period
// counter and the sample handshake live here; each output is a
// pmod_pwm_dac_chan. Defining PMOD_PWM_DAC_SD_EN adds the sd_mode input that
// switches every channel to first-order sigma-delta modulation.
module pmod_pwm_dac
  import pmod_pwm_dac_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  pmod_pwm_dac_if.slave       s_if,
`ifdef PMOD_PWM_DAC_SD_EN
  input  logic                sd_mode,
`endif
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick,
  output logic                underrun
);

  logic [WIDTH-1:0]          counter_q, counter_d;
  logic                      pending_full_q, pending_full_d;
  logic [CHANNELS*WIDTH-1:0] pending_q, pending_d;
  logic                      period_tick_q, period_tick_d;
  logic                      wrap;
  logic                      xfer;
  logic                      load;

  assign wrap = enable && (counter_q == {WIDTH{1'b1}});
  assign xfer = s_if.sample_valid && !pending_full_q;
  assign load = wrap && pending_full_q;

  assign s_if.sample_ready = !pending_full_q;
  assign underrun          = wrap && !pending_full_q;
  assign period_tick       = period_tick_q;

  // Period counter. The tick is registered off counter==0 so it lands on the
  // cycle that carries the first output bit of the new period.
  always_comb begin
    counter_d     = '0;
    period_tick_d = 1'b0;
    if (enable) begin
      counter_d     = counter_q + WIDTH'(1);
      period_tick_d = (counter_q == '0);
    end
  end

  // Pending buffer: filled by a transfer, drained into the channels at a wrap.
  // Load and transfer are mutually exclusive (full vs empty), so a word taken
  // on the wrap cycle waits for the following wrap.
  always_comb begin
    pending_full_d = pending_full_q;
    pending_d      = pending_q;
    if (load) begin
      pending_full_d = 1'b0;
    end
    if (xfer) begin
      pending_full_d = 1'b1;
      pending_d      = s_if.sample;
    end
  end

  // State registers for counter, pending buffer and tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q      <= '0;
      pending_full_q <= 1'b0;
      pending_q      <= '0;
      period_tick_q  <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      pending_full_q <= pending_full_d;
      pending_q      <= pending_d;
      period_tick_q  <= period_tick_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pmod_pwm_dac_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .load     (load),
      .sample_in(pending_q[i*WIDTH +: WIDTH]),
      .counter  (counter_q),
`ifdef PMOD_PWM_DAC_SD_EN
      .sd_mode  (sd_mode),
`endif
      .pwm      (pwm[i])
    );
  end

endmodule
